// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: same-cycle lock/flush controls for PC, IF/ID and RR/EX,
// a redirect-flush state machine, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_redirect_i,
  input  logic             mem_busy_i,
  output logic             pc_lock_o,
  output logic             if_id_lock_o,
  output logic             if_id_flush_o,
  output logic             rr_ex_lock_o,
  output logic             rr_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_FLUSH  = 1'b1;
  localparam logic [3:0]       REM_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [0:0]       state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic redirect_active;
  logic pc_lock, if_id_lock, if_id_flush, rr_ex_lock, rr_ex_flush;

  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  assign redirect_active = ex_redirect_i || (state_q == S_FLUSH);

  // Priority: memory wait freezes everything, then redirect squash, then load-use bubble.
  always_comb begin
    pc_lock     = 1'b0;
    if_id_lock  = 1'b0;
    if_id_flush = 1'b0;
    rr_ex_lock  = 1'b0;
    rr_ex_flush = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        pc_lock    = 1'b1;
        if_id_lock = 1'b1;
        rr_ex_lock = 1'b1;
      end else if (redirect_active) begin
        if_id_flush = 1'b1;
        rr_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_lock     = 1'b1;
        if_id_lock  = 1'b1;
        rr_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_busy_i) begin
      if (ex_redirect_i) begin
        // A redirect inside an ongoing flush restarts the window rather than extending it.
        flush_cnt_d = sat_inc(flush_cnt_q);
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          rem_d   = REM_INIT;
        end
      end else if (state_q == S_FLUSH) begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = S_IDLE;
      end
    end
    if (pc_lock) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_lock_o     = pc_lock;
  assign if_id_lock_o  = if_id_lock;
  assign if_id_flush_o = if_id_flush;
  assign rr_ex_lock_o  = rr_ex_lock;
  assign rr_ex_flush_o = rr_ex_flush;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) driven with directed and random stimulus against a reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, mr = 1'b0, redir = 1'b0, busy = 1'b0;

  logic        pcl_a, ifl_a, iff_a, rrl_a, rrf_a;
  logic        pcl_b, ifl_b, iff_b, rrl_b, rrf_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_rd_i(rd), .ex_memread_i(mr),
    .ex_redirect_i(redir), .mem_busy_i(busy),
    .pc_lock_o(pcl_a), .if_id_lock_o(ifl_a), .if_id_flush_o(iff_a),
    .rr_ex_lock_o(rrl_a), .rr_ex_flush_o(rrf_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_rd_i(rd), .ex_memread_i(mr),
    .ex_redirect_i(redir), .mem_busy_i(busy),
    .pc_lock_o(pcl_b), .if_id_lock_o(ifl_b), .if_id_flush_o(iff_b),
    .rr_ex_lock_o(rrl_b), .rr_ex_flush_o(rrf_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

  // Expected outputs for one cycle: {pc_lock, if_id_lock, if_id_flush, rr_ex_lock, rr_ex_flush}
  typedef struct {
    logic [4:0] out_a;
    logic [4:0] out_b;
    int         sc_a, fc_a, sc_b, fc_b;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: flush cycles still owed after the current one, and plain counters.
  int m_left[2];
  int m_sc[2];
  int m_fc[2];
  int m_fcyc[2] = '{1, 3};
  int m_max[2]  = '{65535, 15};

  task automatic model(input int k, output logic [4:0] o, output int s_pre, output int f_pre);
    bit lu;
    s_pre = m_sc[k];
    f_pre = m_fc[k];
    o = 5'b00000;
    if (rst) begin
      m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      s_pre = 0; f_pre = 0;
      return;
    end
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (busy) begin
      o = 5'b11010;
    end else if (redir || m_left[k] > 0) begin
      o = 5'b00101;
      if (redir) begin
        m_left[k] = m_fcyc[k] - 1;
        m_fc[k] = (m_fc[k] < m_max[k]) ? m_fc[k] + 1 : m_fc[k];
      end else begin
        m_left[k] = m_left[k] - 1;
      end
    end else if (lu) begin
      o = 5'b11001;
    end
    if (o[4]) m_sc[k] = (m_sc[k] < m_max[k]) ? m_sc[k] + 1 : m_sc[k];
  endtask

  task automatic drive(input logic [4:0] i_rs1, input logic [4:0] i_rs2, input logic i_u1,
                       input logic i_u2, input logic [4:0] i_rd, input logic i_mr,
                       input logic i_redir, input logic i_busy, input logic i_rst);
    exp_t e;
    @(posedge clk);
    #1;
    rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2; rd = i_rd;
    mr = i_mr; redir = i_redir; busy = i_busy; rst = i_rst;
    model(0, e.out_a, e.sc_a, e.fc_a);
    model(1, e.out_b, e.sc_b, e.fc_b);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUTs present a full set of outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl_a", int'({pcl_a, ifl_a, iff_a, rrl_a, rrf_a}), int'(e.out_a));
        chk("ctrl_b", int'({pcl_b, ifl_b, iff_b, rrl_b, rrf_b}), int'(e.out_b));
        chk("stall_cnt_a", int'(sc_a), e.sc_a);
        chk("flush_cnt_a", int'(fc_a), e.fc_a);
        chk("stall_cnt_b", int'(sc_b), e.sc_b);
        chk("flush_cnt_b", int'(fc_b), e.fc_b);
        chk("excl_a", int'((iff_a & ifl_a) | (rrf_a & rrl_a)), 0);
        chk("excl_b", int'((iff_b & ifl_b) | (rrf_b & rrl_b)), 0);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0; end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Load-use on rs2, then the same pattern with rd=x0
    drive(0, 5, 0, 1, 5, 1, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0);
    drive(7, 0, 1, 0, 7, 1, 0, 0, 0);
    drive(7, 0, 0, 0, 7, 1, 0, 0, 0);
    idle(1);
    // Single redirect, then back-to-back restart
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    // Memory wait in the last flush cycle with redirect held
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    // Load-use coinciding with redirect
    drive(3, 3, 1, 1, 3, 1, 1, 0, 0);
    idle(3);
    // Counter saturation, then asynchronous reset in the middle of a flush
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(2, 2, 1, 1, 2, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Random traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 299) == 0));
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the producer of the lock/flush controls consumed by the IF/ID and RR/EX pipeline latches and the PC register.
- Detects load-use hazards, resolved branch/jump redirects from EX, and data-memory wait states.
- Drives same-cycle stall (lock) and squash (flush) signals, using a small redirect-flush state machine.
- Keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1: cycles that if_id/rr_ex flush stays asserted per redirect (1..15).
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs1_i  in  5  rs1 of instruction in ID/RR.
- id_rs2_i  in  5  rs2 of instruction in ID/RR.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  5  rd of instruction in EX (RR/EX latch output).
- ex_memread_i  in  1  EX instruction is a load.
- ex_redirect_i  in  1  branch taken or jump resolved in EX this cycle.
- mem_busy_i  in  1  data memory not ready; whole pipe must freeze.
- pc_lock_o  out  1  hold PC.
- if_id_lock_o  out  1  hold IF/ID latch.
- if_id_flush_o  out  1  zero IF/ID latch.
- rr_ex_lock_o  out  1  hold RR/EX latch.
- rr_ex_flush_o  out  1  zero RR/EX latch (bubble).
- stall_cnt_o  out  CNT_W  cycles with pc_lock_o=1.
- flush_cnt_o  out  CNT_W  redirect events accepted.

Behaviour:
- Lock/flush outputs are combinational from registered state plus current inputs. They are valid in the same cycle, so the latches act on the next edge.
- Counters and state are registered.
- Reset (async, rst_i=1):
  - state=IDLE, flush counter=0, stall_cnt_o=0, flush_cnt_o=0.
  - All lock/flush outputs 0 while rst_i is high.
- load_use = ex_memread_i & (ex_rd_i!=0) & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Priority per cycle, highest first:
  1. mem_busy_i=1:
     - pc_lock=if_id_lock=rr_ex_lock=1, both flushes=0.
     - State and flush counter hold.
     - ex_redirect_i and load_use are ignored; EX is frozen, so they are re-evaluated after busy drops.
  2. Redirect, i.e. ex_redirect_i=1 or state=FLUSH:
     - if_id_flush=rr_ex_flush=1, all locks=0 (PC loads the target).
     - load_use is ignored, since the ID instruction is squashed.
  3. load_use:
     - pc_lock=if_id_lock=1, rr_ex_flush=1, rr_ex_lock=0.
     - Exactly one bubble; the next cycle EX holds the bubble, so load_use clears naturally.
  4. Otherwise all outputs 0.
- State machine:
  - States: IDLE, FLUSH; 4-bit remaining counter rem.
  - IDLE -> FLUSH when ex_redirect_i=1, mem_busy_i=0 and FLUSH_CYCLES>1; rem<=FLUSH_CYCLES-1.
  - IDLE stays IDLE on a redirect when FLUSH_CYCLES=1 (single-cycle flush is fully combinational).
  - FLUSH with mem_busy_i=0: rem<=rem-1; return to IDLE after the cycle where rem==1.
  - Redirect arriving in FLUSH: rem reloads to FLUSH_CYCLES-1 (restart); that cycle is not a decrement.
  - mem_busy_i=1 in FLUSH: hold state and rem.
- Counters:
  - stall_cnt_o increments on every cycle with pc_lock_o=1, whether from busy or load_use.
  - flush_cnt_o increments on each cycle with ex_redirect_i=1 and mem_busy_i=0, including restarts.
  - Both saturate at 2^CNT_W-1; no wrap.
- Invariant: a flush and a lock of the same latch are never asserted together.
- Reset mid-FLUSH returns to IDLE immediately; outputs drop asynchronously.

Test Plan:
1. Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 for one cycle, then ex_memread_i=0 -> pc_lock/if_id_lock/rr_ex_flush=1 exactly 1 cycle; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
2. Redirect, FLUSH_CYCLES=3: ex_redirect_i pulse at cycle T -> if_id_flush/rr_ex_flush high T..T+2, low at T+3; flush_cnt_o=1. With FLUSH_CYCLES=1 -> high only at T.
3. Redirect restart, FLUSH_CYCLES=3: second pulse at T+1 -> flushes high T..T+3; flush_cnt_o=2.
4. mem_busy_i high 4 cycles during FLUSH (rem=1) with ex_redirect_i=1 held -> all locks=1, flushes=0 for 4 cycles; after busy drops, flush resumes; stall_cnt_o += 4; flush_cnt_o +1 only on the first non-busy redirect cycle.
5. Load-use and ex_redirect_i in the same cycle -> flushes=1, pc_lock=0, stall_cnt_o unchanged.
6. Saturation and reset, CNT_W=4: 20 busy cycles -> stall_cnt_o=15. Assert rst_i mid-FLUSH -> outputs 0 asynchronously, counters 0, state IDLE.
